// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads opcode and optional operand from ROM at pc,
// pulses exec once per instruction and steers the program counter (increment / jump).
module fetch_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       resetB,
  input  logic [7:0] pc,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       rom_valid,
  input  logic       flagZ,
  input  logic       flagC,
  input  logic       hold,
  output logic       immediate,
  output logic       doJump,
  output logic [7:0] dbus,
  output logic [7:0] ir,
  output logic [7:0] imm,
  output logic       exec,
  output logic       halted,
  output logic       fetch_err
);

  localparam int unsigned WaitW = 8;
  localparam int unsigned DataW = 8;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXEC    = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   ir_q, ir_d;
  logic [DataW-1:0]   imm_q, imm_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               err_q, err_d;

  logic               cond_true;
  logic               take;
  logic               halt_op;
  logic               immediate_c;
  logic               jump_c;
  logic               exec_c;

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      imm_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Condition decode from opcode bits [6:5], evaluated on the live flags.
  always_comb begin
    cond_true = 1'b0;
    case (ir_q[6:5])
      2'b00:   cond_true = 1'b0;
      2'b01:   cond_true = 1'b1;
      2'b10:   cond_true = flagZ;
      default: cond_true = flagC;
    endcase
  end

  assign take    = ir_q[7] & cond_true;
  assign halt_op = ~ir_q[7] & (ir_q[6:5] != 2'b00);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    wait_d      = wait_q;
    err_d       = err_q;
    immediate_c = 1'b0;
    jump_c      = 1'b0;
    exec_c      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        immediate_c = rom_valid;
        if (rom_valid) begin
          ir_d    = rom_data;
          wait_d  = '0;
          state_d = rom_data[7] ? ST_OPERAND : ST_EXEC;
        end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      ST_OPERAND: begin
        immediate_c = rom_valid;
        if (rom_valid) begin
          imm_d   = rom_data;
          wait_d  = '0;
          state_d = ST_EXEC;
        end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      ST_EXEC: begin
        exec_c = 1'b1;
        if (!hold) begin
          jump_c  = take;
          state_d = halt_op ? ST_HALT : ST_FETCH;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State resets to FETCH, so immediate alone needs masking while reset is held.
  assign immediate = resetB & immediate_c;
  assign doJump    = jump_c;
  assign dbus      = jump_c ? imm_q : '0;
  assign exec      = exec_c;
  assign halted    = (state_q == ST_HALT);
  assign rom_addr  = pc;
  assign ir        = ir_q;
  assign imm       = imm_q;
  assign fetch_err = err_q;

endmodule
